// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - requester, ALU and response bundle for alu_sched
interface alu_sched_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [3*NREQ-1:0] req_op;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [2:0]        alu_op;
  logic [7:0]        alu_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_out, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_out, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin sharing of one registered ALU among NREQ requesters
// Optional divide-by-zero flagging under ALU_SCHED_DIV0_CHECK_EN.
module alu_sched #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] id_q;
  logic [7:0]     a_q, b_q, data_q;
  logic [2:0]     op_q;
  logic           valid_q;
  logic [IDW-1:0] grant;
  logic           grant_found;
  logic           accept;
  int             idx;

  // Search starts just past the last winner so nobody is served twice per round.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant       = IDW'(idx);
        grant_found = 1'b1;
      end
    end
  end

  assign accept = rst_n && (state_q == IDLE) && grant_found;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = CAPT;
      CAPT:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_SCHED_DIV0_CHECK_EN
  logic err_q;
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef ALU_SCHED_DIV0_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= bus.req_a[8*int'(grant) +: 8];
        b_q    <= bus.req_b[8*int'(grant) +: 8];
        op_q   <= bus.req_op[3*int'(grant) +: 3];
        id_q   <= grant;
        last_q <= grant;
      end
      if (state_q == CAPT) begin
        valid_q <= 1'b1;
`ifdef ALU_SCHED_DIV0_CHECK_EN
        if (op_q == 3'd3 && b_q == 8'd0) begin
          data_q <= 8'hFF;
          err_q  <= 1'b1;
        end else begin
          data_q <= bus.alu_out;
          err_q  <= 1'b0;
        end
`else
        data_q <= bus.alu_out;
`endif
      end else if (state_q == RESP && bus.rsp_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = accept ? (NREQ'(1) << grant) : '0;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - randomized and directed bench for alu_sched with a transaction-level model
// Expectations for divide-by-zero follow ALU_SCHED_DIV0_CHECK_EN.
module tb_alu_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  alu_sched_if #(.NREQ(4)) bus ();

  alu_sched #(.NREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in registered ALU; a divide by zero yields 0 here.
  always @(posedge clk) begin
    case (bus.alu_op)
      3'd0: bus.alu_out <= bus.alu_a + bus.alu_b;
      3'd1: bus.alu_out <= bus.alu_a - bus.alu_b;
      3'd2: bus.alu_out <= 8'(bus.alu_a * bus.alu_b);
      3'd3: bus.alu_out <= (bus.alu_b == 8'd0) ? 8'd0 : bus.alu_a / bus.alu_b;
      3'd4: bus.alu_out <= bus.alu_a << 1;
      3'd5: bus.alu_out <= bus.alu_a >> 1;
      3'd6: bus.alu_out <= {bus.alu_a[6:0], bus.alu_a[7]};
      default: bus.alu_out <= {bus.alu_a[0], bus.alu_a[7:1]};
    endcase
  end

  logic [3:0] pend;
  int pend_a [4];
  int pend_b [4];
  int pend_op[4];
  int m_last;
  int last_acc;
  int fair_exp [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr();
    for (int k = 1; k <= 4; k++)
      if (pend[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  task automatic exp_result(input int a, input int b, input int op, output int d, output int e);
    e = 0;
    case (op)
      0: d = (a + b) % 256;
      1: d = (a - b + 256) % 256;
      2: d = (a * b) % 256;
      3: begin
        if (b != 0) d = a / b;
        else begin
`ifdef ALU_SCHED_DIV0_CHECK_EN
          d = 255;
          e = 1;
`else
          d = 0;
`endif
        end
      end
      4: d = (a * 2) % 256;
      5: d = a / 2;
      6: d = (a * 2) % 256 + a / 128;
      default: d = a / 2 + (a % 2) * 128;
    endcase
  endtask

  task automatic drive_bus();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i]      = pend[i];
      bus.req_a[8*i +: 8]   = 8'(pend_a[i]);
      bus.req_b[8*i +: 8]   = 8'(pend_b[i]);
      bus.req_op[3*i +: 3]  = 3'(pend_op[i]);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b, input int op);
    pend[i]    = 1'b1;
    pend_a[i]  = a;
    pend_b[i]  = b;
    pend_op[i] = op;
    drive_bus();
  endtask

  task automatic fill_random(input logic [3:0] mask);
    for (int i = 0; i < 4; i++)
      if (mask[i] && !pend[i])
        set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_busy", bus.busy, 0);
  endtask

  // Starts at a negedge with the scheduler idle; ends at the negedge after response acceptance.
  task automatic do_txn(input int stall, input int exp_gap, output int got_id);
    int g, ed, ee;
    drive_bus();
    #1;
    g = rr();
    got_id = -1;
    check("idle_rsp_valid", bus.rsp_valid, 0);
    check("idle_busy", bus.busy, 0);
    if (g < 0) begin
      check("no_req_ready", bus.req_ready, 0);
      return;
    end
    check("req_ready", bus.req_ready, 32'(1 << g));
    @(posedge clk);
    #1;
    if (exp_gap > 0) check("issue_gap", 32'(cyc - last_acc), 32'(exp_gap));
    last_acc = cyc;
    exp_result(pend_a[g], pend_b[g], pend_op[g], ed, ee);
    check("alu_a", bus.alu_a, 32'(pend_a[g]));
    check("alu_b", bus.alu_b, 32'(pend_b[g]));
    check("alu_op", bus.alu_op, 32'(pend_op[g]));
    pend[g] = 1'b0;
    m_last  = g;
    drive_bus();
    @(negedge clk);
    check("exec_busy", bus.busy, 1);
    check("exec_rsp_valid", bus.rsp_valid, 0);
    check("exec_req_ready", bus.req_ready, 0);
    bus.rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("capt_rsp_valid", bus.rsp_valid, 0);
    bus.rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_id", bus.rsp_id, 32'(g));
    check("rsp_data", bus.rsp_data, 32'(ed));
    check("rsp_err", bus.rsp_err, 32'(ee));
    got_id = int'(bus.rsp_id);
    repeat (stall) begin
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_data", bus.rsp_data, 32'(ed));
      check("stall_id", bus.rsp_id, 32'(g));
      check("stall_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rsp_valid", bus.rsp_valid, 0);
    check("post_busy", bus.busy, 0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int id;
    fair_exp = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    pend = '0;
    for (int i = 0; i < 4; i++) begin
      pend_a[i] = 0; pend_b[i] = 0; pend_op[i] = 0;
    end
    m_last = 3;
    last_acc = 0;
    drive_bus();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    set_req(2, 8'h0F, 8'h01, 0);
    do_txn(0, 0, id);
    check("single_id", 32'(id), 2);

    set_req(3, 8'hC8, 8'h03, 2);
    set_req(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);
    do_txn(10, 0, id);
    check("bp_id", 32'(id), 3);
    do_txn(0, 0, id);
    check("bp_next_id", 32'(id), 1);

    for (int op = 4; op < 8; op++) begin
      set_req(0, 8'h81, int'($urandom_range(0, 255)), op);
      do_txn(0, 0, id);
    end

    set_req(2, 8'h20, 8'h00, 3);
    do_txn(1, 0, id);

    for (int n = 0; n < 24; n++) begin
      fill_random(4'($urandom_range(0, 15)));
      if (pend == 4'd0) fill_random(4'(1 << $urandom_range(0, 3)));
      do_txn(int'($urandom_range(0, 2)), 0, id);
    end

    pend = '0;
    set_req(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
    #1;
    check("mid_req_ready", bus.req_ready, 2);
    @(posedge clk);
    #1;
    pend = '0;
    drive_bus();
    @(negedge clk);
    @(negedge clk);
    check("mid_capt_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    m_last = 3;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_valid", bus.rsp_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_after_valid", bus.rsp_valid, 0);

    for (int j = 0; j < 6; j++) begin
      fill_random(4'hF);
      do_txn(0, (j == 0) ? 0 : 4, id);
      check("fair_id", 32'(id), 32'(fair_exp[j]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
